// File: rtl/div_unit_pkg.sv
// Shared divider definitions: FSM state encodings, iteration count and
// the {HI, LO} result ordering used by the EX stage.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_ZERO = 2'b01,
      DIV_BUSY = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

   localparam int DIV_ITERS = 32;

   // 1: result is {HI, LO} = {remainder, quotient}
   localparam bit DIV_HI_IS_REM = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring iteration: shift {rem, quo} left, trial
// subtract the divisor, keep the difference and set quo[0] when it fits.
// Ports: rem_i/quo_i/divisor_i in, rem_o/quo_o out (all DATA_W bits).
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_i,
   input  logic [DATA_W-1:0] quo_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] rem_o,
   output logic [DATA_W-1:0] quo_o
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] trial;
   logic            fits;

   assign shifted = {rem_i, quo_i[DATA_W-1]};
   assign trial   = shifted - {1'b0, divisor_i};
   // compare on the unsigned shifted value so a zero divisor always fits
   assign fits    = shifted >= {1'b0, divisor_i};

   assign rem_o = fits ? DATA_W'(trial) : DATA_W'(shifted);
   assign quo_o = {quo_i[DATA_W-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; result_o = {rem, quo}.
// Ports: clk, rst (sync high), start_i, annul_i, signed_i, dividend_i,
// divider_i -> result_o, success_o (registered), busy_o.
// Optional macro DIV_ZERO_FAST_EN: zero divisor returns 0 after 2 cycles.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_ITERS,
   parameter int ITERS  = DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              annul_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divider_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic              success_o,
   output logic              busy_o
);

   localparam int CW = $clog2(ITERS);

   div_state_e        state;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] dvs;
   logic              neg_q;
   logic              neg_r;

   logic [DATA_W-1:0] step_rem;
   logic [DATA_W-1:0] step_quo;
   logic [DATA_W-1:0] fix_rem;
   logic [DATA_W-1:0] fix_quo;

   function automatic logic [DATA_W-1:0] mag(
      input logic [DATA_W-1:0] v,
      input logic              s
   );
      return (s && v[DATA_W-1]) ? -v : v;
   endfunction

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem_i     (rem),
      .quo_i     (quo),
      .divisor_i (dvs),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   assign fix_rem = neg_r ? -step_rem : step_rem;
   assign fix_quo = neg_q ? -step_quo : step_quo;

   assign busy_o = (state == DIV_BUSY) || (state == DIV_ZERO);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DIV_IDLE;
         success_o <= 1'b0;
         result_o  <= '0;
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
      end else if (annul_i) begin
         state     <= DIV_IDLE;
         success_o <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_i) begin
                  neg_q <= signed_i &
                           (dividend_i[DATA_W-1] ^ divider_i[DATA_W-1]);
                  neg_r <= signed_i & dividend_i[DATA_W-1];
                  rem   <= '0;
                  quo   <= mag(dividend_i, signed_i);
                  dvs   <= mag(divider_i, signed_i);
                  cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
                  state <= (divider_i == '0) ? DIV_ZERO : DIV_BUSY;
`else
                  state <= DIV_BUSY;
`endif
               end
            end
            DIV_BUSY: begin
               rem <= step_rem;
               quo <= step_quo;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(ITERS - 1)) begin
                  state     <= DIV_DONE;
                  success_o <= 1'b1;
                  result_o  <= DIV_HI_IS_REM ? {fix_rem, fix_quo}
                                             : {fix_quo, fix_rem};
               end
            end
`ifdef DIV_ZERO_FAST_EN
            DIV_ZERO: begin
               state     <= DIV_DONE;
               success_o <= 1'b1;
               result_o  <= '0;
            end
`endif
            DIV_DONE: begin
               if (!start_i) begin
                  state     <= DIV_IDLE;
                  success_o <= 1'b0;
               end
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit with a transaction-level
// reference model; build with +define+DIV_ZERO_FAST_EN for the fast path.
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic        signed_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divider_i = '0;
   logic [63:0] result_o;
   logic        success_o;
   logic        busy_o;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   div_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .annul_i    (annul_i),
      .signed_i   (signed_i),
      .dividend_i (dividend_i),
      .divider_i  (divider_i),
      .result_o   (result_o),
      .success_o  (success_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // {rem, quo} from the arithmetic definition of DIV/DIVU
   function automatic logic [63:0] ref_div(input logic s,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] ma, mb, q, r;
      ma = (s && a[31]) ? 32'(0 - a) : a;
      mb = (s && b[31]) ? 32'(0 - b) : b;
      if (mb == 0) begin
         q = 32'hFFFF_FFFF;
         r = ma;
      end else begin
         q = ma / mb;
         r = ma % mb;
      end
      if (s && (a[31] != b[31])) q = 32'(0 - q);
      if (s && a[31]) r = 32'(0 - r);
      return {r, q};
   endfunction

   // transaction model: a request accepted on edge N completes on
   // edge N+32 (N+1 for the fast zero path)
   int          cyc = 0;
   int          m_due = 0;
   bit          m_busy = 0;
   bit          m_succ = 0;
   logic [63:0] m_res = '0;
   logic [63:0] m_pend = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_busy = 0;
         m_succ = 0;
         m_res  = '0;
      end else if (annul_i) begin
         m_busy = 0;
         m_succ = 0;
      end else if (m_succ) begin
         if (!start_i) m_succ = 0;
      end else if (m_busy) begin
         if (cyc == m_due) begin
            m_succ = 1;
            m_res  = m_pend;
            m_busy = 0;
         end
      end else if (start_i) begin
         m_busy = 1;
         if (FAST && divider_i == 0) begin
            m_pend = '0;
            m_due  = cyc + 1;
         end else begin
            m_pend = ref_div(signed_i, dividend_i, divider_i);
            m_due  = cyc + 32;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_success", 64'(success_o), 64'(m_succ));
         chk("cyc_result", result_o, m_res);
         chk("cyc_busy", 64'(busy_o), 64'(m_busy));
      end
   end

   // hold start until success (bounded), optionally scrambling operands
   // after edge scr; then drop start for one edge
   task automatic run_div(input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int scr,
                          input int hold, output logic [63:0] res);
      int lat;
      int exp_lat;
      bit seen;
      signed_i = s;
      dividend_i = a;
      divider_i = b;
      start_i = 1'b1;
      exp_lat = (FAST && b == 0) ? 2 : 33;
      seen = 0;
      lat = 0;
      res = '0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (k == scr) begin
            dividend_i = $urandom;
            divider_i = $urandom;
            signed_i = ~signed_i;
         end
         if (success_o) begin
            seen = 1;
            lat = k;
         end
      end
      if (!seen) chk("success_timeout", 64'(0), 64'(1));
      else chk("latency", 64'(lat), 64'(exp_lat));
      res = result_o;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
      end
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_success", 64'(success_o), 64'(0));
   endtask

   logic [63:0] r;

   initial begin
      // model pins
      chk("ref_100_7", ref_div(0, 32'd100, 32'd7), {32'd2, 32'd14});
      chk("ref_m7_2", ref_div(1, 32'hFFFF_FFF9, 32'd2),
          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      chk("ref_min_m1", ref_div(1, 32'h8000_0000, 32'hFFFF_FFFF),
          {32'd0, 32'h8000_0000});
      chk("ref_7_0", ref_div(0, 32'd7, 32'd0), {32'd7, 32'hFFFF_FFFF});
      chk("ref_50_5", ref_div(0, 32'd50, 32'd5), {32'd0, 32'd10});

      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      rst = 1'b0;
      chk("rst_result", result_o, 64'd0);
      chk("rst_success", 64'(success_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);

      run_div(0, 32'd100, 32'd7, 0, 0, r);
      chk("udiv_100_7", r, {32'd2, 32'd14});
      run_div(1, 32'hFFFF_FFF9, 32'd2, 0, 1, r);
      chk("sdiv_m7_2", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, r);
      chk("sdiv_min_m1", r, {32'd0, 32'h8000_0000});
      run_div(0, 32'd5, 32'd0, 0, 0, r);
      chk("div_zero", r, FAST ? 64'd0 : {32'd5, 32'hFFFF_FFFF});
      // back-to-back: run_div leaves start low for exactly one edge
      run_div(0, 32'd50, 32'd5, 0, 0, r);
      chk("b2b_50_5", r, {32'd0, 32'd10});
      run_div(0, 32'd1234567, 32'd89, 5, 0, r);
      chk("scramble", r, {32'd48, 32'd13871});

      // annul mid-division
      signed_i = 1'b0;
      dividend_i = 32'd1000;
      divider_i = 32'd3;
      start_i = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      chk("annul_busy", 64'(busy_o), 64'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("annul_nosucc", 64'(success_o), 64'd0);
      run_div(0, 32'd9, 32'd3, 0, 0, r);
      chk("after_annul", r, {32'd0, 32'd3});

      // reset mid-division
      dividend_i = 32'd777;
      divider_i = 32'd5;
      start_i = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      rst = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_success", 64'(success_o), 64'd0);
      chk("midrst_result", result_o, 64'd0);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      rst = 1'b0;

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         logic [31:0] a, b;
         logic s;
         int mode;
         s = 1'($urandom);
         a = $urandom;
         mode = $urandom_range(0, 3);
         case (mode)
            0: b = $urandom;
            1: b = $urandom_range(0, 15);
            2: b = 32'd0;
            default: begin
               b = 32'hFFFF_FFFF;
               a = 32'h8000_0000;
            end
         endcase
         if ($urandom_range(0, 7) == 0) begin
            signed_i = s;
            dividend_i = a;
            divider_i = b;
            start_i = 1'b1;
            repeat ($urandom_range(1, 30)) @(posedge clk);
            #1;
            annul_i = 1'b1;
            start_i = 1'b0;
            @(posedge clk);
            #1;
            annul_i = 1'b0;
         end else begin
            run_div(s, a, b, $urandom_range(0, 34),
                    $urandom_range(0, 2), r);
            chk("rand_result", r,
                (FAST && b == 0) ? 64'd0 : ref_div(s, a, b));
         end
      end

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle restoring divider sequenced by a four-state FSM, serving the EX stage's DIV/DIVU path. EX holds `start_i` high and requests a pipeline pause until `success_o` rises. The unit then returns `{remainder, quotient}` on `result_o`, which EX writes to `{HI, LO}`. An exception flush can abort a division in flight through `annul_i`.

## Interface
- `DATA_W`, default 32: operand width. The result is `2*DATA_W` bits.
- `ITERS`, default `DATA_W`: number of restoring iterations. It is fixed equal to `DATA_W`.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  division request; held high by EX until it sees `success_o`.
- `annul_i`  in  1  abort (pipeline flush); takes priority over `start_i`.
- `signed_i`  in  1  1 = DIV, 0 = DIVU; sampled with operands.
- `dividend_i`  in  `DATA_W`  dividend.
- `divider_i`  in  `DATA_W`  divisor.
- `result_o`  out  `2*DATA_W`  `{remainder, quotient}`; registered.
- `success_o`  out  1  result valid; registered.
- `busy_o`  out  1  high in BUSY/ZERO; combinational from the state register.

## Operation
States: IDLE, ZERO, BUSY, DONE.

Reset:
- State goes to IDLE; `success_o`, `result_o` and the iteration counter go to 0.
- Reset mid-division discards the division; nothing is output.

Transitions, evaluated in this priority order:
- Any state with `annul_i`=1: go to IDLE next cycle, with `success_o`=0. `result_o` holds its last value.
- IDLE with `start_i`=1:
  - Latch `signed_i` and the operand signs.
  - Latch magnitudes: `abs()` when signed, raw when unsigned.
  - Clear the partial remainder; counter = 0.
  - Go to ZERO if the divisor is 0 and `DIV_ZERO_FAST_EN` is defined; otherwise go to BUSY.
- BUSY: perform one restoring step per cycle.
  - Shift `{rem, quo}` left by 1.
  - Trial = `rem − divisor` (`DATA_W+1` bits).
  - If the trial is non-negative: `rem` = trial, `quo[0]` = 1.
  - After the step with counter = `ITERS−1`, go to DONE and register the corrected result with `success_o`=1.
- ZERO: register `result_o` = 0 and `success_o`=1; go to DONE.
- DONE: hold `success_o`=1 and `result_o`. Go to IDLE when `start_i`=0, clearing `success_o`.

Operand handling:
- Operand inputs are ignored outside IDLE, so changes mid-division have no effect.

Sign correction, signed mode only:
- Negate the quotient iff the dividend and divisor signs differ.
- Negate the remainder iff the dividend is negative.
- Arithmetic wraps mod 2^`DATA_W`. Therefore −2^31 / −1 gives quotient 0x80000000, remainder 0.

## Timing
- Start sampled in IDLE at cycle 0: BUSY occupies cycles 1..32, and `success_o`=1 from cycle 33.
- Zero fast path: `success_o`=1 from cycle 2.
- `success_o` stays high until the first cycle after `start_i` falls. Then it is low, and IDLE can accept a new start on that same cycle.
- `annul_i` with `start_i` in the same IDLE cycle: the start is not accepted.
- No back-pressure exists beyond the `start_i` level.

## Configuration
`DIV_ZERO_FAST_EN` controls divide-by-zero handling.
- Defined: a zero divisor takes ZERO and returns `result_o`=0 at cycle 2.
- Undefined: the ZERO state is absent. A zero divisor runs the full 32 iterations and yields the raw restoring result plus sign correction. For example, unsigned 7/0 gives quotient 0xFFFFFFFF, remainder 7.

## Structure
- Shared package/defines holds:
  - state encodings `DIV_IDLE`, `DIV_ZERO`, `DIV_BUSY`, `DIV_DONE` (2 bits);
  - `DIV_ITERS`;
  - the `{HI, LO}` = `{rem, quo}` ordering constant used by EX.
- One sub-module is natural: `div_step`, a purely combinational single restoring iteration (shift, trial subtract, select).
- FSM, counter, latches and sign correction stay in `div_unit`.

## Test plan
- Unsigned 100 / 7, `start_i` held → `success_o` at cycle 33, `result_o` = {2, 14}; drop `start_i` → `success_o`=0 next cycle.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Divisor 0, dividend 5:
  - With `DIV_ZERO_FAST_EN`: `success_o` at cycle 2, `result_o`=0.
  - Without it: cycle 33, {5, 0xFFFFFFFF}.
- `annul_i` pulsed at BUSY cycle 10 → IDLE next cycle, `success_o` never rises; a fresh start of 9/3 then gives {0, 3} at +33.
- `rst` asserted at BUSY cycle 20 → IDLE, `success_o`=0, `result_o`=0 next cycle; operands changed mid-BUSY have no effect on result.
- Back-to-back: drop `start_i` for exactly one cycle after success, re-raise with 50/5 → second `success_o` 33 cycles after re-accept, `result_o` = {0, 10}.
